// File: rtl/noc_vc_input_buffer.sv
// Per-port virtual-channel input buffer: one circular FIFO per VC, head-of-queue presentation and credit return.
// Optional per-VC packet framing checks are enabled by defining NOC_VC_PROTOCOL_CHECK_EN.
module noc_vc_input_buffer #(
    parameter int  FLIT_WIDTH = 64,
    parameter int  VC_NUM     = 2,
    parameter int  FIFO_DEPTH = 4,
    localparam int VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [VC_W-1:0]              in_vc,
    input  logic [FLIT_WIDTH-1:0]        in_flit,
    output logic [VC_NUM-1:0]            credit_out,
    output logic [VC_NUM-1:0]            out_valid,
    output logic [VC_NUM*FLIT_WIDTH-1:0] out_flit,
    output logic [VC_NUM-1:0]            out_head,
    output logic [VC_NUM-1:0]            out_tail,
    input  logic [VC_NUM-1:0]            out_pop,
    output logic [VC_NUM*CNT_W-1:0]      vc_count,
    output logic [VC_NUM-1:0]            proto_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [1:0] in_type_s;
    assign in_type_s = in_flit[FLIT_WIDTH-1 -: 2];

`ifdef NOC_VC_PROTOCOL_CHECK_EN
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} pkt_state_e;
`endif

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic [FLIT_WIDTH-1:0] ram_r [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr_r;
        logic [PTR_W-1:0]      rd_ptr_r;
        logic [CNT_W-1:0]      count_r;
        logic                  credit_r;
        logic                  sel_s;
        logic                  pop_s;
        logic                  fit_s;
        logic                  wr_s;

        assign sel_s = in_valid && (in_vc == VC_W'(v));
        assign pop_s = out_pop[v] && (count_r != {CNT_W{1'b0}});
        // A full FIFO still has room when its head leaves on the same edge.
        assign fit_s = (count_r != FULL_CNT) || pop_s;

`ifdef NOC_VC_PROTOCOL_CHECK_EN
        pkt_state_e state_r;
        logic       pend_r;
        logic       err_r;
        logic       frame_ok_s;
        logic       drop_s;

        // Head/single open a packet from IDLE; body/tail continue one in ACTIVE (type bit 0 set = opens a packet).
        always_comb begin
            frame_ok_s = 1'b0;
            case (state_r)
                IDLE:    frame_ok_s = in_type_s[0];
                ACTIVE:  frame_ok_s = ~in_type_s[0];
                default: frame_ok_s = 1'b0;
            endcase
        end

        assign wr_s   = sel_s && fit_s && frame_ok_s;
        assign drop_s = sel_s && !frame_ok_s;

        // Packet state, sticky error and credit return; a pending drop credit drains first.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r  <= IDLE;
                err_r    <= 1'b0;
                pend_r   <= 1'b0;
                credit_r <= 1'b0;
            end else begin
                if (wr_s && (in_type_s == 2'b01)) begin
                    state_r <= ACTIVE;
                end else if (wr_s && (in_type_s == 2'b10)) begin
                    state_r <= IDLE;
                end
                if (sel_s && (!frame_ok_s || !fit_s)) begin
                    err_r <= 1'b1;
                end
                credit_r <= pend_r | pop_s | drop_s;
                pend_r   <= (pend_r & (pop_s | drop_s)) | (pop_s & drop_s);
            end
        end

        assign proto_err[v] = err_r;
`else
        assign wr_s = sel_s && fit_s;

        // One credit per accepted pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                credit_r <= 1'b0;
            end else begin
                credit_r <= pop_s;
            end
        end

        assign proto_err[v] = 1'b0;
`endif

        // Pointers and occupancy; reset discards everything buffered.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (wr_s) begin
                    wr_ptr_r <= next_ptr(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= next_ptr(rd_ptr_r);
                end
                count_r <= count_r + CNT_W'(wr_s) - CNT_W'(pop_s);
            end
        end

        // Flit storage is deliberately left unreset.
        always_ff @(posedge clk) begin
            if (wr_s) begin
                ram_r[wr_ptr_r] <= in_flit;
            end
        end

        assign out_valid[v]                          = (count_r != {CNT_W{1'b0}});
        assign out_flit[v*FLIT_WIDTH +: FLIT_WIDTH]  = ram_r[rd_ptr_r];
        assign out_head[v]                           = ram_r[rd_ptr_r][FLIT_WIDTH-2];
        assign out_tail[v]                           = ram_r[rd_ptr_r][FLIT_WIDTH-1];
        assign vc_count[v*CNT_W +: CNT_W]            = count_r;
        assign credit_out[v]                         = credit_r;
    end

endmodule
